// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
//
// Single-stage instruction decoder for an 8-bit instruction word. The word
// splits into a class in [7:6], field A in [5:3] and field B in [2:0]. A valid
// instruction is decoded combinationally and registered on the next rising
// clk edge, which gives one cycle of latency. When no instruction is
// presented, the decoded outputs hold their values and out_valid drops.
//
// Build option:
//   ILLEGAL_TRAP_EN - when defined, an illegal encoding produces a trap
//                     decode: opcode = 8'h80 and all addresses and the ALU
//                     mode are zero. When undefined, opcode[7] is always 0
//                     and an illegal word decodes like any other word of
//                     its class.
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset; clears every output
//   instr_valid  in   1  instruction present this cycle
//   instruction  in   8  {class[1:0], field_a[2:0], field_b[2:0]}
//   out_valid    out  1  outputs were loaded by a valid instruction last cycle
//   operand_1    out  3  raw field A
//   operand_2    out  3  raw field B (condition code for the COND class)
//   opcode       out  8  decode flags:
//                          [0] IMM  [1] ALU  [2] COPY  [3] COND
//                          [4] COPY reads the input port (A = 110)
//                          [5] COPY writes the output port (B = 110)
//                          [6] register-file write  [7] illegal (trap build)
//   iaddr        out  3  source register address
//   oaddr        out  3  destination register address
//   alu_mode     out  4  ALU control; 0000 = idle
// ---------------------------------------------------------------------------
module instr_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instruction,
  output logic       out_valid,
  output logic [2:0] operand_1,
  output logic [2:0] operand_2,
  output logic [7:0] opcode,
  output logic [2:0] iaddr,
  output logic [2:0] oaddr,
  output logic [3:0] alu_mode
);

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;

  localparam logic [2:0] PORT_SEL = 3'b110;  // register index aliased to I/O port
  localparam logic [2:0] REG_R0   = 3'd0;
  localparam logic [2:0] REG_R1   = 3'd1;
  localparam logic [2:0] REG_R3   = 3'd3;

  localparam int OPC_IMM    = 0;
  localparam int OPC_ALU    = 1;
  localparam int OPC_COPY   = 2;
  localparam int OPC_COND   = 3;
  localparam int OPC_PORTIN = 4;
  localparam int OPC_PORTOUT = 5;
  localparam int OPC_RFWR   = 6;
`ifdef ILLEGAL_TRAP_EN
  localparam int OPC_ILL    = 7;
`endif

  logic [1:0] cls;
  logic [2:0] fld_a;
  logic [2:0] fld_b;

  assign cls   = instruction[7:6];
  assign fld_a = instruction[5:3];
  assign fld_b = instruction[2:0];

  logic [7:0] d_opcode;
  logic [2:0] d_iaddr;
  logic [2:0] d_oaddr;
  logic [3:0] d_alu_mode;

`ifdef ILLEGAL_TRAP_EN
  logic illegal;

  // ALU instructions reserve field A as zero; register 7 does not exist as a
  // COPY source or destination.
  always_comb begin
    illegal = 1'b0;
    case (cls)
      CLS_ALU:  illegal = (fld_a != 3'b000);
      CLS_COPY: illegal = (fld_a == 3'b111) || (fld_b == 3'b111);
      default:  illegal = 1'b0;
    endcase
  end
`endif

  always_comb begin
    d_opcode   = '0;
    d_iaddr    = REG_R0;
    d_oaddr    = REG_R0;
    d_alu_mode = 4'b0000;

    case (cls)
      CLS_IMM: begin
        // r0 is loaded with the 6-bit immediate carried in [5:0]
        d_opcode[OPC_IMM]  = 1'b1;
        d_opcode[OPC_RFWR] = 1'b1;
      end
      CLS_ALU: begin
        d_opcode[OPC_ALU]  = 1'b1;
        d_opcode[OPC_RFWR] = 1'b1;
        d_iaddr            = REG_R1;
        d_oaddr            = REG_R3;
        d_alu_mode         = {1'b1, fld_b};
      end
      CLS_COPY: begin
        d_opcode[OPC_COPY]    = 1'b1;
        d_opcode[OPC_PORTIN]  = (fld_a == PORT_SEL);
        d_opcode[OPC_PORTOUT] = (fld_b == PORT_SEL);
        // destinations 110/111 are not register-file entries
        d_opcode[OPC_RFWR]    = (fld_b <= 3'b101);
        d_iaddr               = fld_a;
        d_oaddr               = fld_b;
      end
      CLS_COND: begin
        // r3 is the tested register; the condition code rides on operand_2
        d_opcode[OPC_COND] = 1'b1;
        d_iaddr            = REG_R3;
      end
      default: begin
        d_opcode = '0;
      end
    endcase

`ifdef ILLEGAL_TRAP_EN
    if (illegal) begin
      d_opcode          = '0;
      d_opcode[OPC_ILL] = 1'b1;
      d_iaddr           = REG_R0;
      d_oaddr           = REG_R0;
      d_alu_mode        = 4'b0000;
    end
`endif
  end

  // out_valid follows instr_valid every cycle; the decoded fields load only
  // on a valid instruction so they hold across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      operand_1 <= '0;
      operand_2 <= '0;
      opcode    <= '0;
      iaddr     <= '0;
      oaddr     <= '0;
      alu_mode  <= '0;
    end else begin
      out_valid <= instr_valid;
      if (instr_valid) begin
        operand_1 <= fld_a;
        operand_2 <= fld_b;
        opcode    <= d_opcode;
        iaddr     <= d_iaddr;
        oaddr     <= d_oaddr;
        alu_mode  <= d_alu_mode;
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
module tb_instr_decoder;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instruction;
  logic       out_valid;
  logic [2:0] operand_1;
  logic [2:0] operand_2;
  logic [7:0] opcode;
  logic [2:0] iaddr;
  logic [2:0] oaddr;
  logic [3:0] alu_mode;

  int checks = 0;
  int errors = 0;

  instr_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .out_valid   (out_valid),
    .operand_1   (operand_1),
    .operand_2   (operand_2),
    .opcode      (opcode),
    .iaddr       (iaddr),
    .oaddr       (oaddr),
    .alu_mode    (alu_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] instr;
    logic [2:0] op1;
    logic [2:0] op2;
    logic [7:0] opc;
    logic [2:0] ia;
    logic [2:0] oa;
    logic [3:0] alu;
  } vec_t;

  vec_t vecs[14];

  // Packed view: {out_valid, operand_1, operand_2, opcode, iaddr, oaddr, alu_mode}
  function automatic logic [24:0] pack_exp(logic v, vec_t e);
    return {v, e.op1, e.op2, e.opc, e.ia, e.oa, e.alu};
  endfunction

  function automatic logic [24:0] pack_act();
    return {out_valid, operand_1, operand_2, opcode, iaddr, oaddr, alu_mode};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b op1=%b op2=%b opc=%b ia=%b oa=%b alu=%b, expected v=%b op1=%b op2=%b opc=%b ia=%b oa=%b alu=%b",
               name, act[24], act[23:21], act[20:18], act[17:10], act[9:7], act[6:4], act[3:0],
               exp[24], exp[23:21], exp[20:18], exp[17:10], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask

  function automatic vec_t mk(string n, logic [7:0] i, logic [7:0] opc,
                              logic [2:0] ia, logic [2:0] oa, logic [3:0] alu);
    vec_t v;
    v.name = n; v.instr = i; v.op1 = i[5:3]; v.op2 = i[2:0];
    v.opc = opc; v.ia = ia; v.oa = oa; v.alu = alu;
    return v;
  endfunction

  vec_t zero_v;
  vec_t held;

  initial begin
    vecs[0]  = mk("imm_00011111",  8'b00_011_111, 8'b0100_0001, 3'd0, 3'd0, 4'b0000);
    vecs[1]  = mk("alu_01000010",  8'b01_000_010, 8'b0100_0010, 3'd1, 3'd3, 4'b1010);
    vecs[2]  = mk("cond_11000100", 8'b11_000_100, 8'b0000_1000, 3'd3, 3'd0, 4'b0000);
    vecs[3]  = mk("copy_portin",   8'b10_110_010, 8'b0101_0100, 3'd6, 3'd2, 4'b0000);
    vecs[4]  = mk("copy_portout",  8'b10_001_110, 8'b0010_0100, 3'd1, 3'd6, 4'b0000);
`ifdef ILLEGAL_TRAP_EN
    vecs[5]  = mk("ill_copy_a111", 8'b10_111_000, 8'b1000_0000, 3'd0, 3'd0, 4'b0000);
    vecs[6]  = mk("ill_alu_a101",  8'b01_101_011, 8'b1000_0000, 3'd0, 3'd0, 4'b0000);
    vecs[7]  = mk("ill_copy_b111", 8'b10_000_111, 8'b1000_0000, 3'd0, 3'd0, 4'b0000);
`else
    vecs[5]  = mk("ill_copy_a111", 8'b10_111_000, 8'b0100_0100, 3'd7, 3'd0, 4'b0000);
    vecs[6]  = mk("ill_alu_a101",  8'b01_101_011, 8'b0100_0010, 3'd1, 3'd3, 4'b1011);
    vecs[7]  = mk("ill_copy_b111", 8'b10_000_111, 8'b0000_0100, 3'd0, 3'd7, 4'b0000);
`endif
    vecs[8]  = mk("alu_01000111",  8'b01_000_111, 8'b0100_0010, 3'd1, 3'd3, 4'b1111);
    vecs[9]  = mk("copy_b101",     8'b10_101_101, 8'b0100_0100, 3'd5, 3'd5, 4'b0000);
    vecs[10] = mk("imm_00111111",  8'b00_111_111, 8'b0100_0001, 3'd0, 3'd0, 4'b0000);
    vecs[11] = mk("cond_11111111", 8'b11_111_111, 8'b0000_1000, 3'd3, 3'd0, 4'b0000);
    vecs[12] = mk("copy_port_io",  8'b10_110_110, 8'b0011_0100, 3'd6, 3'd6, 4'b0000);
    vecs[13] = mk("alu_01000000",  8'b01_000_000, 8'b0100_0010, 3'd1, 3'd3, 4'b1000);

    zero_v = mk("zero", 8'h00, 8'h00, 3'd0, 3'd0, 4'b0000);

    // reset state
    rst_n = 1'b0; instr_valid = 1'b0; instruction = 8'h00;
    #2;
    check("reset_async", pack_act(), pack_exp(1'b0, zero_v));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", pack_act(), pack_exp(1'b0, zero_v));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_release_idle", pack_act(), pack_exp(1'b0, zero_v));

    // table: one instruction per cycle, back-to-back
    for (int i = 0; i < 14; i++) begin
      instr_valid = 1'b1;
      instruction = vecs[i].instr;
      @(negedge clk);
      check(vecs[i].name, pack_act(), pack_exp(1'b1, vecs[i]));
    end

    // idle for 3 cycles with junk on the bus: fields hold, out_valid low
    held = vecs[13];
    instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      instruction = 8'b10_110_010 ^ 8'(k);
      @(negedge clk);
      check($sformatf("idle_hold_%0d", k), pack_act(), pack_exp(1'b0, held));
    end

    // resumption after idle
    instr_valid = 1'b1;
    instruction = vecs[3].instr;
    @(negedge clk);
    check("resume_after_idle", pack_act(), pack_exp(1'b1, vecs[3]));

    // reset pulsed mid-cycle: outputs clear before the next edge
    instruction = vecs[1].instr;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midcycle", pack_act(), pack_exp(1'b0, zero_v));
    // valid instruction in flight across the edge while reset is held
    @(negedge clk);
    check("reset_discard", pack_act(), pack_exp(1'b0, zero_v));
    rst_n = 1'b1;
    instruction = vecs[0].instr;
    @(negedge clk);
    check("first_after_reset", pack_act(), pack_exp(1'b1, vecs[0]));

    instr_valid = 1'b0;
    @(negedge clk);
    check("valid_drop_after_reset", pack_act(), pack_exp(1'b0, vecs[0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all registered outputs.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: instr_valid  input  1  instruction present this cycle.
REQ-004 SHALL have ports: instruction  input  8  instruction byte; [7:6] class, [5:3] field A, [2:0] field B.
REQ-005 SHALL have ports: out_valid  output  1  decoded outputs updated by a valid instruction last cycle.
REQ-006 SHALL have ports: operand_1  output  3  field A, i.e. instruction[5:3].
REQ-007 SHALL have ports: operand_2  output  3  field B, i.e. instruction[2:0].
REQ-008 SHALL have ports: opcode  output  8  decode flag vector, bits defined in REQ-014.
REQ-009 SHALL have ports: iaddr  output  3  source register address.
REQ-010 SHALL have ports: oaddr  output  3  destination register address.
REQ-011 SHALL have ports: alu_mode  output  4  ALU control; 0000 = ALU idle.

Function
REQ-012 SHALL register all outputs on rising clk when instr_valid=1: one-cycle latency, out_valid=1 the following cycle.
REQ-013 SHALL, when instr_valid=0, hold operand_1, operand_2, opcode, iaddr, oaddr and alu_mode, and drive out_valid=0 the next cycle.
REQ-014 SHALL define opcode bits:
- bit0 IMM (class 00)
- bit1 ALU (class 01)
- bit2 COPY (class 10)
- bit3 COND (class 11)
- bit4 COPY with A=110 (reads input port)
- bit5 COPY with B=110 (writes output port)
- bit6 register-file write: IMM, ALU, or COPY with B<=101
- bit7 illegal (REQ-020)
REQ-015 SHALL decode IMM (00): iaddr=000, oaddr=000 (r0 receives 6-bit immediate instruction[5:0]), alu_mode=0000.
REQ-016 SHALL decode ALU (01): iaddr=001, oaddr=011, alu_mode={1'b1, instruction[2:0]}.
REQ-017 SHALL decode COPY (10): iaddr=instruction[5:3], oaddr=instruction[2:0], alu_mode=0000.
REQ-018 SHALL decode COND (11): iaddr=011 (r3 tested), oaddr=000, alu_mode=0000; condition code is operand_2.
REQ-019 SHALL drive operand_1/operand_2 from raw fields for every class, including illegal instructions.
REQ-020 SHALL classify as illegal: ALU with A!=000; COPY with A=111 or B=111.

Reset
REQ-021 SHALL, while rst_n=0 (immediately, independent of clk), force every output, including out_valid, to zero.
REQ-022 SHALL, on reset assertion mid-operation, discard any in-flight decode; the first valid instruction after release decodes normally one cycle later.

Configuration
REQ-023 SHALL honour macro ILLEGAL_TRAP_EN:
- defined: illegal instruction gives opcode=1000_0000, iaddr=000, oaddr=000, alu_mode=0000.
- undefined: opcode[7] is constant 0; illegal encodings decode per REQ-014..REQ-018 with no trap.

Verification
REQ-024 SHALL cover: instruction=00_011_111, valid -> next cycle operand_1=011, operand_2=111, opcode=0100_0001, iaddr=000, oaddr=000, alu_mode=0000, out_valid=1.
REQ-025 SHALL cover: 01_000_010 -> opcode=0100_0010, iaddr=001, oaddr=011, alu_mode=1010; then 11_000_100 -> opcode=0000_1000, iaddr=011, alu_mode=0000.
REQ-026 SHALL cover: 10_110_010 -> opcode=0101_0100, iaddr=110, oaddr=010; then 10_001_110 -> opcode=0010_0100, oaddr=110.
REQ-027 SHALL cover: 10_111_000 -> opcode=1000_0000 with ILLEGAL_TRAP_EN; opcode=0100_0100, iaddr=111 without.
REQ-028 SHALL cover: instr_valid=0 for 3 cycles -> outputs held, out_valid=0.
REQ-029 SHALL cover: rst_n pulsed low mid-cycle -> all outputs 0 before next clk edge.
